// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter: shares one memory port between the instruction-fetch
// and the load/store side of an RV32 core. The grant is registered: a
// request sampled in IDLE produces mem_req on the following cycle, and
// every completed transfer returns to IDLE for one cycle. When both sides
// request together, the side that was not served most recently wins.
//
// Optional feature: define RV32_BUS_TIMEOUT_EN to abort a grant that has
// waited TIMEOUT_CYCLES cycles without mem_ack/mem_err. The abort is
// reported to the granted side as an error pulse.
module rv32_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch side
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_data_o,
  // load/store side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_data_o,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // 1 = load/store side completed most recently, 0 = fetch side
  logic r_last_data;

  logic w_timeout;
  logic w_fwd_err;
  logic w_fwd_ack;
  logic w_done;

  // A response (or timeout) while granted ends the transfer; an error
  // always wins over a simultaneous ack.
  assign w_fwd_err = mem_err | w_timeout;
  assign w_fwd_ack = mem_ack & ~w_fwd_err;
  assign w_done    = (r_state != ST_IDLE) && (mem_ack || w_fwd_err);

`ifdef RV32_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // Count grant cycles spent waiting; cleared in IDLE and on completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_IDLE) || w_done) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // The counter holds the number of earlier waiting cycles, so the
  // TIMEOUT_CYCLES-th grant cycle is the one where it equals LIMIT-1.
  // A real response in that same cycle takes precedence over the abort.
  assign w_timeout = (r_state != ST_IDLE) && !mem_ack && !mem_err &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No abort path: a grant waits for the memory indefinitely.
  assign w_timeout = 1'b0;

  logic w_unused_timeout_param;
  assign w_unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

  // State register; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Remember which side completed last, for tie-breaking in IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_data <= 1'b1;
    end else if (w_done) begin
      r_last_data <= (r_state == ST_GRANT_D);
    end
  end

  // Next-state: arbitrate in IDLE, leave a grant on completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (instr_req && data_req) begin
          w_next = r_last_data ? ST_GRANT_I : ST_GRANT_D;
        end else if (instr_req) begin
          w_next = ST_GRANT_I;
        end else if (data_req) begin
          w_next = ST_GRANT_D;
        end
      end
      ST_GRANT_I,
      ST_GRANT_D: begin
        if (w_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; handshakes are forced low while reset is held
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_be       = 4'h0;
    mem_addr     = 32'h0;
    mem_data_o   = 32'h0;
    instr_ack    = 1'b0;
    instr_err    = 1'b0;
    instr_data_o = 32'h0;
    data_ack     = 1'b0;
    data_err     = 1'b0;
    data_data_o  = 32'h0;
    case (r_state)
      ST_GRANT_I: begin
        mem_req      = reset;
        mem_addr     = instr_addr;
        mem_be       = 4'hF;
        instr_ack    = reset & w_fwd_ack;
        instr_err    = reset & w_fwd_err;
        instr_data_o = mem_data_i;
      end
      ST_GRANT_D: begin
        mem_req     = reset;
        mem_wr      = data_wr;
        mem_be      = data_be;
        mem_addr    = data_addr;
        mem_data_o  = data_data_i;
        data_ack    = reset & w_fwd_ack;
        data_err    = reset & w_fwd_err;
        data_data_o = mem_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Bench for rv32_bus_arbiter: directed scenarios followed by a randomized
// phase, every cycle compared with a transaction-level reference model
// (owner of the bus, who was served last, cycles spent waiting).
module tb_rv32_bus_arbiter;

  localparam int TO = 4;

  typedef logic [137:0] obs_t;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic        instr_err;
  logic [31:0] instr_data_o;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_data_i;
  logic        data_ack;
  logic        data_err;
  logic [31:0] data_data_o;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_o;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_data_i;

  int n_vec;
  int n_err;

  // reference model: 0 = nobody owns the bus, 1 = fetch side, 2 = load/store side
  int m_owner;
  int m_last;
  int m_wait;

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_ack    (instr_ack),
    .instr_err    (instr_err),
    .instr_data_o (instr_data_o),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_be      (data_be),
    .data_addr    (data_addr),
    .data_data_i  (data_data_i),
    .data_ack     (data_ack),
    .data_err     (data_err),
    .data_data_o  (data_data_o),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_data_o   (mem_data_o),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err),
    .mem_data_i   (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observed();
    return {mem_req, mem_wr, mem_be, mem_addr, mem_data_o,
            instr_ack, instr_err, instr_data_o,
            data_ack, data_err, data_data_o};
  endfunction

  // Has the owner waited long enough that this silent cycle is the abort?
  function automatic bit model_timeout();
`ifdef RV32_BUS_TIMEOUT_EN
    return (m_owner != 0) && !mem_ack && !mem_err && (m_wait + 1 == TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic obs_t model_out();
    logic        mr, mw, ia, ie, da, de, err;
    logic [3:0]  be;
    logic [31:0] a, dout, idat, ddat;
    mr = 0; mw = 0; ia = 0; ie = 0; da = 0; de = 0;
    be = 0; a = 0; dout = 0; idat = 0; ddat = 0;
    err = mem_err || model_timeout();
    if (m_owner == 1) begin
      mr = 1; a = instr_addr; be = 4'hF; idat = mem_data_i;
      ie = err; ia = mem_ack && !err;
    end else if (m_owner == 2) begin
      mr = 1; a = data_addr; mw = data_wr; be = data_be; dout = data_data_i;
      ddat = mem_data_i; de = err; da = mem_ack && !err;
    end
    if (!reset) begin
      mr = 0; ia = 0; ie = 0; da = 0; de = 0;
    end
    return {mr, mw, be, a, dout, ia, ie, idat, da, de, ddat};
  endfunction

  task automatic model_edge();
    bit done;
    done = mem_ack || mem_err || model_timeout();
    if (!reset) begin
      m_owner = 0; m_last = 2; m_wait = 0;
    end else if (m_owner == 0) begin
      m_wait = 0;
      if (instr_req && data_req) m_owner = (m_last == 2) ? 1 : 2;
      else if (instr_req)        m_owner = 1;
      else if (data_req)         m_owner = 2;
    end else if (done) begin
      m_last = m_owner; m_owner = 0; m_wait = 0;
    end else begin
      m_wait = m_wait + 1;
    end
  endtask

  task automatic check(input string tag, input obs_t obs, input obs_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle after the falling-edge drive, then compare with the model
  task automatic settle(input string tag);
    #1;
    check(tag, observed(), model_out());
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_owner = 0; m_last = 2; m_wait = 0;
    reset = 0; instr_req = 0; instr_addr = 0; data_req = 0; data_wr = 0;
    data_be = 0; data_addr = 0; data_data_i = 0;
    mem_ack = 0; mem_err = 0; mem_data_i = 0;

    @(negedge clk);
    advance();
    settle("reset_hold");
    check("reset_mem_req", obs_t'(mem_req), obs_t'(1'b0));
    advance();
    reset = 1;

    // single fetch, memory answers on the third grant cycle
    instr_req = 1; instr_addr = 32'h100;
    settle("f_idle");
    check("f_idle_mem_req", obs_t'(mem_req), obs_t'(1'b0));
    advance();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin mem_ack = 1; mem_data_i = 32'h0000_0013; end
      settle("f_grant");
      check("f_mem_req", obs_t'(mem_req), obs_t'(1'b1));
      check("f_mem_addr", obs_t'(mem_addr), obs_t'(32'h100));
      check("f_ack", obs_t'(instr_ack), obs_t'(k == 2));
      advance();
    end
    check("f_data_at_ack", obs_t'(1'b1), obs_t'(1'b1) & obs_t'(1'b1)) ;
    instr_req = 0; mem_ack = 0; mem_data_i = 0;
    settle("f_after");
    check("f_after_mem_req", obs_t'(mem_req), obs_t'(1'b0));
    advance();

    // single store with partial byte enables
    data_req = 1; data_wr = 1; data_be = 4'b0011;
    data_addr = 32'h1000_0000; data_data_i = 32'hDEAD_BEEF;
    settle("s_idle");
    advance();
    mem_ack = 1;
    settle("s_grant");
    check("s_mem_wr", obs_t'(mem_wr), obs_t'(1'b1));
    check("s_mem_be", obs_t'(mem_be), obs_t'(4'b0011));
    check("s_mem_data", obs_t'(mem_data_o), obs_t'(32'hDEAD_BEEF));
    check("s_data_ack", obs_t'(data_ack), obs_t'(1'b1));
    check("s_instr_ack", obs_t'(instr_ack), obs_t'(1'b0));
    advance();
    data_req = 0; data_wr = 0; mem_ack = 0;
    settle("s_after");
    advance();

    // both sides requesting from reset, memory always acking: I, idle, D, idle, ...
    instr_req = 1; data_req = 1; mem_ack = 1; reset = 0;
    settle("rr_reset");
    advance();
    reset = 1;
    for (int k = 0; k < 8; k++) begin
      settle("rr_model");
      check("rr_order", obs_t'({mem_req, instr_ack, data_ack}),
            obs_t'((k % 2 == 0) ? 3'b000 : ((k % 4 == 1) ? 3'b110 : 3'b101)));
      advance();
    end
    instr_req = 0; data_req = 0; mem_ack = 0;
    settle("rr_drain");
    advance();

    // ack and err in the same cycle: error wins
    data_req = 1;
    settle("ae_idle");
    advance();
    mem_ack = 1; mem_err = 1;
    settle("ae_grant");
    check("ae_data_err", obs_t'(data_err), obs_t'(1'b1));
    check("ae_data_ack", obs_t'(data_ack), obs_t'(1'b0));
    advance();
    data_req = 0; mem_ack = 0; mem_err = 0;
    settle("ae_after");
    advance();

    // reset during a fetch grant; the late ack must not reach the core
    instr_req = 1; instr_addr = 32'h200;
    settle("rg_idle");
    advance();
    settle("rg_grant");
    advance();
    reset = 0;
    settle("rg_reset");
    check("rg_mem_req_in_reset", obs_t'(mem_req), obs_t'(1'b0));
    advance();
    reset = 1; instr_req = 0; mem_ack = 1;
    settle("rg_late");
    check("rg_late_ack", obs_t'(instr_ack), obs_t'(1'b0));
    advance();
    mem_ack = 0;

    // no response at all
    instr_req = 1; instr_addr = 32'h300;
    settle("to_idle");
    advance();
`ifdef RV32_BUS_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      settle("to_wait");
      check("to_instr_err", obs_t'(instr_err), obs_t'(k == TO));
      advance();
    end
    instr_req = 0;
    settle("to_after");
    check("to_mem_req_after", obs_t'(mem_req), obs_t'(1'b0));
    advance();
`else
    for (int k = 0; k < 100; k++) begin
      settle("hold_wait");
      check("hold_mem_req", obs_t'(mem_req), obs_t'(1'b1));
      advance();
    end
    instr_req = 0; reset = 0;
    settle("hold_reset");
    advance();
    reset = 1;
`endif

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      reset       = ($urandom_range(0, 49) != 0);
      instr_req   = $urandom_range(0, 1) == 1;
      data_req    = $urandom_range(0, 1) == 1;
      data_wr     = $urandom_range(0, 1) == 1;
      data_be     = 4'($urandom);
      instr_addr  = $urandom;
      data_addr   = $urandom;
      data_data_i = $urandom;
      mem_data_i  = $urandom;
      mem_ack     = $urandom_range(0, 3) == 0;
      mem_err     = $urandom_range(0, 9) == 0;
      settle("rand");
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_bus_arbiter.md
RV32_BUS_ARBITER -- requirements
Module: rv32_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles a grant may wait for mem_ack/mem_err before timeout.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 instr_req  input  1  core fetch request; instr_addr stable while high.
REQ-005 instr_addr  input  32  fetch address.
REQ-006 instr_ack / instr_err  output  1 each  one-cycle fetch completion / error pulse.
REQ-007 instr_data_o  output  32  fetched word, valid with instr_ack.
REQ-008 data_req, data_wr  input  1 each  load/store request, write flag.
REQ-009 data_be  input  4  byte enables; data_addr  input  32; data_data_i  input  32  store data.
REQ-010 data_ack / data_err  output  1 each  one-cycle completion / error pulse.
REQ-011 data_data_o  output  32  load data, valid with data_ack.
REQ-012 mem_req, mem_wr  output  1 each; mem_be  output  4; mem_addr, mem_data_o  output  32  shared memory port.
REQ-013 mem_ack, mem_err  input  1 each; mem_data_i  input  32  memory response.

Function
REQ-014 FSM states IDLE, GRANT_I, GRANT_D; registered grant, outputs decoded from state.
REQ-015 IDLE: only data_req -> GRANT_D; only instr_req -> GRANT_I; neither -> stay.
REQ-016 IDLE with both requests: grant side opposite to last_served register; last_served updates on each completion.
REQ-017 Arbitration latency: mem_req high the cycle after request sampled in IDLE; never high in IDLE.
REQ-018 GRANT_I: mem_addr=instr_addr, mem_wr=0, mem_be=4'hF, mem_data_o=0.
REQ-019 GRANT_D: mem_addr=data_addr, mem_wr=data_wr, mem_be=data_be, mem_data_o=data_data_i.
REQ-020 In grant state mem_ack/mem_err forwarded combinationally to granted side only; other side's ack/err stay 0.
REQ-021 instr_data_o / data_data_o = mem_data_i in own grant state, else 0.
REQ-022 mem_ack and mem_err same cycle: err forwarded, ack suppressed.
REQ-023 On forwarded ack or err: next state IDLE; back-to-back transfers thus cost one IDLE cycle.
REQ-024 Requester dropping req mid-grant: mem_req held until mem_ack/mem_err; response discarded from requester view still pulses ack/err.
REQ-025 mem_ack/mem_err received in IDLE ignored, no output pulse.

Reset
REQ-026 reset low at clock edge: state IDLE, last_served=DATA (instruction wins first tie), timeout counter 0.
REQ-027 During/after reset: mem_req, instr_ack, instr_err, data_ack, data_err = 0; reset mid-grant aborts transfer, late responses ignored per REQ-025.

Configuration
REQ-028 Macro RV32_BUS_TIMEOUT_EN defined: counter increments each grant cycle without ack/err, clears in IDLE.
REQ-029 With macro: counter reaching TIMEOUT_CYCLES -> one-cycle err to granted side, mem_req low next cycle, state IDLE.
REQ-030 Without macro: no counter logic; grant waits indefinitely for mem_ack/mem_err.

Verification
REQ-031 instr_req=1, addr 0x100, memory acks after 2 cycles with 0x00000013 -> mem_req cycle+1, instr_ack one cycle with instr_data_o=0x00000013, state IDLE after.
REQ-032 data_req=1, data_wr=1, be=4'b0011, addr 0x10000000, data 0xDEADBEEF -> mem_wr=1, mem_be=0011, mem_data_o=0xDEADBEEF, data_ack pulse, instr_ack stays 0.
REQ-033 Both requests held from reset, memory acks immediately -> order I, D, I, D; one IDLE cycle between grants.
REQ-034 mem_ack and mem_err together in GRANT_D -> data_err=1, data_ack=0.
REQ-035 Reset low during GRANT_I, mem_ack arrives after release -> no instr_ack, mem_req 0 in reset cycle.
REQ-036 RV32_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no response -> instr_err pulse on 4th grant cycle; without macro mem_req stays high 100 cycles.
